// File: rtl/cpu6_dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: word width, FSM encoding, wait counter width.
// Optional byte-mask writes are enabled with CPU6_DMEM_BYTEMASK_EN.
package cpu6_dmem_responder_pkg;

    localparam int CPU6_XLEN          = 32;
    localparam int CPU6_DMEM_CNT_SIZE = 4;

    typedef enum logic [1:0] {
        CPU6_DMEM_IDLE = 2'd0,
        CPU6_DMEM_BUSY = 2'd1,
        CPU6_DMEM_RESP = 2'd2
    } cpu6_dmem_state_t;

    // Byte lanes touched by a masked access starting at byte offset ofs;
    // any bit in [7:4] means the access spills into the next word.
    function automatic logic [7:0] cpu6_dmem_lanes(input logic [3:0] mask, input logic [1:0] ofs);
        return {4'b0000, mask} << ofs;
    endfunction

endpackage

// File: rtl/cpu6_dmem_ram.sv
// Plain synchronous single-port word array, kept separate so an SRAM macro can drop in.
// Byte enables exist only when CPU6_DMEM_BYTEMASK_EN is defined.
module cpu6_dmem_ram
    import cpu6_dmem_responder_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                 clk,
    input  logic                 i_en,
    input  logic                 i_we,
    input  logic [AW-1:0]        i_addr,
    input  logic [CPU6_XLEN-1:0] i_wdata,
`ifdef CPU6_DMEM_BYTEMASK_EN
    input  logic [3:0]           i_be,
`endif
    output logic [CPU6_XLEN-1:0] o_rdata
);

    logic [CPU6_XLEN-1:0] r_mem [DEPTH];
    logic [CPU6_XLEN-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_we) begin
`ifdef CPU6_DMEM_BYTEMASK_EN
                for (int b = 0; b < 4; b++) begin
                    if (i_be[b]) begin
                        r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
                    end
                end
`else
                r_mem[i_addr] <= i_wdata;
`endif
            end else begin
                r_rdata <= r_mem[i_addr];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/cpu6_dmem_responder.sv
// Data-memory responder: one access at a time, WAIT_CYCLES wait states, one-cycle ready pulse.
// Byte-masked writes are added when CPU6_DMEM_BYTEMASK_EN is defined.
module cpu6_dmem_responder
    import cpu6_dmem_responder_pkg::*;
#(
    parameter int                   DEPTH_WORDS = 1024,
    parameter int                   WAIT_CYCLES = 1,
    parameter logic [CPU6_XLEN-1:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 memreqM,
    input  logic                 memwriteM,
    input  logic [CPU6_XLEN-1:0] dataaddr,
    input  logic [CPU6_XLEN-1:0] writedata,
`ifdef CPU6_DMEM_BYTEMASK_EN
    input  logic [3:0]           bytemask,
`endif
    output logic [CPU6_XLEN-1:0] readdata,
    output logic                 ready,
    output logic                 err
);

    localparam int                   AW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [CPU6_XLEN-1:0] DEPTH_X = CPU6_XLEN'(DEPTH_WORDS);

    cpu6_dmem_state_t            r_state;
    logic [CPU6_DMEM_CNT_SIZE-1:0] r_cnt;
    logic                        r_write;
    logic [CPU6_XLEN-1:0]        r_addr;
    logic [CPU6_XLEN-1:0]        r_wdata;
    logic                        r_ready;
    logic                        r_err;
    logic                        r_rd_ok;

    logic [CPU6_XLEN-1:0]        w_off;
    logic [CPU6_XLEN-1:0]        w_index;
    logic                        w_range_err;
    logic                        w_align_err;
    logic                        w_err;
    logic                        w_access;
    logic                        w_we;
    logic [CPU6_XLEN-1:0]        w_ram_wdata;
    logic [CPU6_XLEN-1:0]        w_ram_q;

    // Underflow of addr-BASE_ADDR is caught by the explicit compare, not by wrap.
    assign w_off       = r_addr - BASE_ADDR;
    assign w_index     = w_off >> 2;
    assign w_range_err = (r_addr < BASE_ADDR) || (w_index >= DEPTH_X);

`ifdef CPU6_DMEM_BYTEMASK_EN
    logic [3:0] r_mask;
    logic [7:0] w_lanes;

    assign w_lanes     = cpu6_dmem_lanes(r_mask, r_addr[1:0]);
    assign w_align_err = r_write ? (w_lanes[7:4] != 4'b0000) : (r_addr[1:0] != 2'b00);
    assign w_ram_wdata = r_wdata << {r_addr[1:0], 3'b000};
`else
    assign w_align_err = (r_addr[1:0] != 2'b00);
    assign w_ram_wdata = r_wdata;
`endif

    assign w_err    = w_range_err || w_align_err;
    assign w_access = (r_state == CPU6_DMEM_BUSY) && (r_cnt == '0);
    assign w_we     = w_access && r_write && !w_err;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= CPU6_DMEM_IDLE;
            r_cnt   <= '0;
            r_write <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            r_rd_ok <= 1'b0;
`ifdef CPU6_DMEM_BYTEMASK_EN
            r_mask  <= 4'b0000;
`endif
        end else begin
            case (r_state)
                CPU6_DMEM_IDLE: begin
                    if (memreqM) begin
                        r_write <= memwriteM;
                        r_addr  <= dataaddr;
                        r_wdata <= writedata;
`ifdef CPU6_DMEM_BYTEMASK_EN
                        r_mask  <= bytemask;
`endif
                        r_cnt   <= CPU6_DMEM_CNT_SIZE'(WAIT_CYCLES);
                        r_state <= CPU6_DMEM_BUSY;
                    end
                end
                CPU6_DMEM_BUSY: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_ready <= 1'b1;
                        r_err   <= w_err;
                        r_rd_ok <= !r_write && !w_err;
                        r_state <= CPU6_DMEM_RESP;
                    end
                end
                CPU6_DMEM_RESP: begin
                    r_ready <= 1'b0;
                    r_err   <= 1'b0;
                    r_rd_ok <= 1'b0;
                    r_state <= CPU6_DMEM_IDLE;
                end
                default: r_state <= CPU6_DMEM_IDLE;
            endcase
        end
    end

    cpu6_dmem_ram #(
        .DEPTH (DEPTH_WORDS),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .i_en    (w_access),
        .i_we    (w_we),
        .i_addr  (w_index[AW-1:0]),
        .i_wdata (w_ram_wdata),
`ifdef CPU6_DMEM_BYTEMASK_EN
        .i_be    (w_lanes[3:0]),
`endif
        .o_rdata (w_ram_q)
    );

    // The array output is only meaningful in the ready cycle of a good read.
    assign readdata = r_rd_ok ? w_ram_q : '0;
    assign ready    = r_ready;
    assign err      = r_err;

endmodule

// File: doc/cpu6_dmem_responder.md
Name: cpu6_dmem_responder

Overview:
- Data-memory responder: the far end of the core's data-memory port (memwriteM / dataaddr / writedata out of the core, readdata back into it).
- Holds word storage and serves one request at a time after a programmable number of wait states.
- Returns a one-cycle ready pulse that the hazard control uses to stall the pipeline.
- Sits beside the core in the top level, replacing the zero-latency combinational data memory.

Parameters:
- DEPTH_WORDS, 1024: number of CPU6_XLEN-bit words stored; must be a power of two.
- WAIT_CYCLES, 1: extra wait states per access; legal range 0..15.
- BASE_ADDR, 32'h0000_0000: byte address of word 0.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  reset, asynchronous, active-low.
- memreqM  in  1  request valid; core holds request stable until ready.
- memwriteM  in  1  1 = write, 0 = read.
- dataaddr  in  CPU6_XLEN  byte address.
- writedata  in  CPU6_XLEN  write data.
- readdata  out  CPU6_XLEN  read data; meaningful only while ready=1.
- ready  out  1  one-cycle completion pulse.
- err  out  1  error flag, qualified by ready.

Behaviour:
- Reset (reset=0, async): state=IDLE, cnt=0, readdata=0, ready=0, err=0. Storage array is NOT cleared. Reset mid-access aborts the access; a pending write is discarded.
- State machine, three states (IDLE, BUSY, RESP):
  - IDLE: on an edge with memreqM=1, capture write/addr/wdata into internal registers, load cnt=WAIT_CYCLES, go to BUSY.
  - BUSY: if cnt!=0, cnt-=1 and stay. If cnt==0, perform the access on that edge and go to RESP.
  - RESP: ready=1 for exactly this cycle; next edge returns to IDLE unconditionally.
- Latency: request sampled at edge E0 -> ready high from edge E0+WAIT_CYCLES+1 until edge E0+WAIT_CYCLES+2.
- Throughput: one access per WAIT_CYCLES+3 cycles. A request is never accepted in BUSY or RESP; memreqM is ignored there.
- Access on the BUSY->RESP edge:
  - Word index = (addr-BASE_ADDR)>>2.
  - Write: stores captured wdata; readdata=0.
  - Read: readdata <= mem[index].
- Error, checked on captured address:
  - Misaligned (addr[1:0]!=0) or out of range (addr<BASE_ADDR, or index>=DEPTH_WORDS) -> err=1 in RESP, write suppressed, readdata=0.
  - err=0 whenever ready=0.
- Address arithmetic is unsigned CPU6_XLEN-bit with no wrap. addr-BASE_ADDR underflow counts as out of range.
- Inputs are captured only at acceptance; later changes in BUSY do not affect the access.
- Read after write to the same word, as separate requests, returns the new data.
- memreqM=1 held through RESP into IDLE is sampled as a new request on the IDLE edge; the core must drop memreqM in the ready cycle unless it issues another access.

Optional Feature:
- Macro: CPU6_DMEM_BYTEMASK_EN.
- Defined:
  - Extra input port bytemask (4 bits), captured at acceptance.
  - Write updates only bytes whose mask bit=1; mask 4'b0000 writes nothing but still completes with ready.
  - Alignment check relaxes to "the enabled bytes lie within one word".
  - Reads ignore the mask and return the full word.
- Undefined: no bytemask port; all writes are full-word.

Decomposition:
- Shared defines file additions:
  - state encoding CPU6_DMEM_IDLE/BUSY/RESP (2 bits);
  - CPU6_DMEM_CNT_SIZE=4.
- CPU6_XLEN is reused from the existing defines.
- One sub-module: cpu6_dmem_ram, a plain synchronous single-port array with write enable (and byte enables under the macro), so it can be swapped for an SRAM macro.
- FSM, counter and error checks stay in the top module.

Test Plan:
- Reset: reset=0 mid-BUSY of a write to 0x10 -> ready/err/readdata=0; after release, read of 0x10 returns the prior contents, not the new data.
- WAIT_CYCLES=2: write 0xDEADBEEF to 0x40 accepted at edge 0 -> ready high only between edges 3 and 4, err=0. Read of 0x40 -> readdata=0xDEADBEEF in its ready cycle.
- WAIT_CYCLES=0: read 0x0 -> ready in cycle after edge 1. memreqM held high -> second access accepted at edge 3, ready after edge 4.
- Error cases:
  - Read addr 0x42 -> err=1, readdata=0.
  - Write addr 4*DEPTH_WORDS -> err=1, and a later read of word 0 is unchanged, proving no aliasing.
- Changing dataaddr and writedata during BUSY -> the access uses the values captured at acceptance.
- With CPU6_DMEM_BYTEMASK_EN: word 0x11223344, write 0xAABBCCDD with mask 4'b0101 -> read returns 0x11BB33DD.
